sr_controller: RTL and testbench
================================

// Module: sr_controller
// PURPOSE
//   Multi-cycle control FSM for the Simple RISC Machine datapath. Consumes opcode/op from the
//   instruction decoder and drives its register-select (nsel) and the datapath load/mux/write
//   strobes. Handshake with the outside is s (start) / w (waiting). One state per clock.
// PARAMETERS
//   STATE_W  4  state register width; must be >= 3. Encodings come from sr_ctrl_pkg.
// PORTS
//   clk      in   1  single clock, rising edge
//   reset_n  in   1  asynchronous, active-low reset
//   s        in   1  start; sampled only in S_WAIT
//   opcode   in   3  instruction bits [15:13], from the decoder
//   op       in   2  instruction bits [12:11], from the decoder
//   w        out  1  1 only in S_WAIT: ready for a new instruction
//   nsel     out  3  one-hot register select: 001 Rn, 010 Rd, 100 Rm, 000 none
//   vsel     out  2  write-back source: 2'b00 C, 2'b10 sximm8 (others reserved, never driven)
//   loada    out  1  load A register
//   loadb    out  1  load B register
//   loadc    out  1  load C register
//   loads    out  1  load status flags
//   asel     out  1  1 = ALU A input forced to 0
//   bsel     out  1  1 = ALU B input is sximm5 (always 0 for the supported set)
//   write    out  1  register-file write enable
//   illegal  out  1  undefined instruction seen (see CONFIGURATION)
// BEHAVIOUR
//   - Reset (async, any state, mid-instruction included): state=S_WAIT, latched opcode/op=0.
//     All outputs 0 except w=1. write deasserts immediately, with no clock edge required.
//   - Moore outputs, decoded from state (+ latched opcode/op). No combinational path from an input.
//   - S_WAIT with s=1: latch {opcode,op} and go to S_DECODE. All later decisions use the latched copy.
//     s=0: stay in S_WAIT.
//   - S_DECODE, on the latched value:
//     110/10 MOV imm -> S_WRITE_IMM
//     110/00 MOV reg -> S_GET_B
//     101/11 MVN     -> S_GET_B
//     101/00 ADD, 101/01 CMP, 101/10 AND -> S_GET_A
//     anything else  -> undefined-instruction handling (CONFIGURATION)
//   - State outputs. Any output not listed is 0.
//     S_WRITE_IMM: nsel=001, vsel=10, write=1 -> S_WAIT
//     S_GET_A:     nsel=001, loada=1 -> S_GET_B
//     S_GET_B:     nsel=100, loadb=1 -> S_ALU
//     S_ALU:       asel=1 for MOV reg/MVN; loads=1 and loadc=0 for CMP, else loadc=1
//                  -> CMP: S_WAIT; others: S_WRITE_REG
//     S_WRITE_REG: nsel=010, vsel=00, write=1 -> S_WAIT
//   - Latency, counted in edges from the edge that samples s=1 until w=1 again:
//     MOV imm 3; MOV reg/MVN 5; CMP 5; ADD/AND 6.
//   - If s is still 1 on return to S_WAIT, w is high for exactly one cycle and the next
//     instruction starts. Changes on opcode/op while w=0 are ignored.
// CONFIGURATION
//   SR_ILLEGAL_TRAP_EN defined:
//     undefined opcode/op -> S_HALT. Outputs are all 0 except illegal=1; w=0.
//     S_HALT exits only through reset_n.
//   SR_ILLEGAL_TRAP_EN undefined:
//     undefined opcode/op -> S_WAIT as a no-op (no write). illegal is tied to 0.
//     S_HALT is unreachable.
// STRUCTURE
//   - sr_ctrl_pkg holds:
//     state_t enum: S_WAIT, S_DECODE, S_WRITE_IMM, S_GET_A, S_GET_B, S_ALU, S_WRITE_REG, S_HALT
//     OPC_MOV=3'b110, OPC_ALU=3'b101
//     OP_ADD/OP_CMP/OP_AND/OP_MVN, OP_MOVIMM/OP_MOVREG
//     NSEL_RN/RD/RM, VSEL_C/VSEL_IMM8
//   - One sub-module, sr_ctrl_outdec: purely combinational, (state, latched opcode/op) -> the
//     strobe outputs. sr_controller holds the state and latch registers and the next-state logic.
// TESTING
//   1. Reset with reset_n=0 mid-S_ALU (ADD) -> same cycle: w=1, write=0, loadc=0;
//      after release, FSM in S_WAIT.
//   2. opcode=110, op=10, s=1 for one cycle -> S_DECODE, then S_WRITE_IMM (nsel=001, vsel=10,
//      write=1), w=1 on edge 3.
//   3. opcode=101, op=00 (ADD) -> loada with nsel=001, loadb with nsel=100, loadc=1 asel=0,
//      write with nsel=010 vsel=00; w=1 on edge 6.
//   4. CMP (101/01) -> S_ALU asserts loads=1 and loadc=0; write never asserted; w=1 on edge 5.
//   5. MVN (101/11) with opcode switched to 110/10 during S_GET_B -> still the MVN path
//      (asel=1, write to Rd); s held high -> w=1 for one cycle, then the next instruction starts.
//   6. opcode=111 -> with SR_ILLEGAL_TRAP_EN: illegal=1 and w=0 indefinitely until reset_n;
//      without it: w=1 two edges after start, no write.

Source files
------------

// File: rtl/sr_ctrl_pkg.sv
// rtl/sr_ctrl_pkg.sv - state encodings and instruction field constants for the SRM control FSM
//
// Shared by sr_controller and sr_ctrl_outdec.
//   state_t        : FSM states (3-bit encoding; the controller's state register may be wider)
//   OPC_* / OP_*   : opcode [15:13] and op [12:11] values of the supported instruction set
//   NSEL_* / VSEL_*: register-select and write-back source encodings driven to the datapath
package sr_ctrl_pkg;

    typedef enum logic [2:0] {
        S_WAIT      = 3'd0,
        S_DECODE    = 3'd1,
        S_WRITE_IMM = 3'd2,
        S_GET_A     = 3'd3,
        S_GET_B     = 3'd4,
        S_ALU       = 3'd5,
        S_WRITE_REG = 3'd6,
        S_HALT      = 3'd7
    } state_t;

    localparam logic [2:0] OPC_MOV    = 3'b110;
    localparam logic [2:0] OPC_ALU    = 3'b101;

    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_AND     = 2'b10;
    localparam logic [1:0] OP_MVN     = 2'b11;
    localparam logic [1:0] OP_MOVIMM  = 2'b10;
    localparam logic [1:0] OP_MOVREG  = 2'b00;

    localparam logic [2:0] NSEL_NONE  = 3'b000;
    localparam logic [2:0] NSEL_RN    = 3'b001;
    localparam logic [2:0] NSEL_RD    = 3'b010;
    localparam logic [2:0] NSEL_RM    = 3'b100;

    localparam logic [1:0] VSEL_C     = 2'b00;
    localparam logic [1:0] VSEL_IMM8  = 2'b10;

    // CMP only updates the status flags; it never produces a result in C.
    function automatic logic is_cmp(input logic [2:0] opc, input logic [1:0] op);
        return (opc == OPC_ALU) && (op == OP_CMP);
    endfunction

    // Single-operand instructions pass B through the ALU with A forced to zero.
    function automatic logic is_single_op(input logic [2:0] opc, input logic [1:0] op);
        return ((opc == OPC_MOV) && (op == OP_MOVREG)) ||
               ((opc == OPC_ALU) && (op == OP_MVN));
    endfunction

endpackage

// File: rtl/sr_ctrl_outdec.sv
// rtl/sr_ctrl_outdec.sv - combinational Moore output decoder for the SRM control FSM
//
// Ports:
//   state   in   state_t  current FSM state
//   opcode  in   3        latched opcode
//   op      in   2        latched op
//   w, nsel, vsel, loada, loadb, loadc, loads, asel, bsel, write, illegal  out  datapath strobes
// Optional feature macro: SR_ILLEGAL_TRAP_EN (illegal=1 in S_HALT; otherwise tied to 0).
import sr_ctrl_pkg::*;

module sr_ctrl_outdec (
    input  state_t      state,
    input  logic [2:0]  opcode,
    input  logic [1:0]  op,
    output logic        w,
    output logic [2:0]  nsel,
    output logic [1:0]  vsel,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        asel,
    output logic        bsel,
    output logic        write,
    output logic        illegal
);

    always_comb begin
        w       = 1'b0;
        nsel    = NSEL_NONE;
        vsel    = VSEL_C;
        loada   = 1'b0;
        loadb   = 1'b0;
        loadc   = 1'b0;
        loads   = 1'b0;
        asel    = 1'b0;
        bsel    = 1'b0;
        write   = 1'b0;
        illegal = 1'b0;
        case (state)
            S_WAIT: w = 1'b1;
            S_WRITE_IMM: begin
                nsel  = NSEL_RN;
                vsel  = VSEL_IMM8;
                write = 1'b1;
            end
            S_GET_A: begin
                nsel  = NSEL_RN;
                loada = 1'b1;
            end
            S_GET_B: begin
                nsel  = NSEL_RM;
                loadb = 1'b1;
            end
            S_ALU: begin
                asel = is_single_op(opcode, op);
                if (is_cmp(opcode, op)) begin
                    loads = 1'b1;
                end else begin
                    loadc = 1'b1;
                end
            end
            S_WRITE_REG: begin
                nsel  = NSEL_RD;
                vsel  = VSEL_C;
                write = 1'b1;
            end
            S_HALT: begin
`ifdef SR_ILLEGAL_TRAP_EN
                illegal = 1'b1;
`else
                illegal = 1'b0;
`endif
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/sr_controller.sv
// rtl/sr_controller.sv - multi-cycle control FSM for the Simple RISC Machine datapath
//
// Ports:
//   clk      in   1  clock, rising edge
//   reset_n  in   1  asynchronous active-low reset
//   s        in   1  start, sampled only in S_WAIT
//   opcode   in   3  instruction [15:13]
//   op       in   2  instruction [12:11]
//   w        out  1  ready for a new instruction (S_WAIT)
//   nsel     out  3  one-hot register select (Rn/Rd/Rm)
//   vsel     out  2  write-back source
//   loada, loadb, loadc, loads, asel, bsel, write  out  datapath strobes
//   illegal  out  1  undefined instruction trapped
// Parameter STATE_W (>= 3): state register width; upper bits stay zero.
// Optional feature macro: SR_ILLEGAL_TRAP_EN (undefined instructions halt until reset_n).
import sr_ctrl_pkg::*;

module sr_controller #(
    parameter int STATE_W = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        s,
    input  logic [2:0]  opcode,
    input  logic [1:0]  op,
    output logic        w,
    output logic [2:0]  nsel,
    output logic [1:0]  vsel,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        asel,
    output logic        bsel,
    output logic        write,
    output logic        illegal
);

    logic [STATE_W-1:0] state_q;
    logic [2:0]         opc_q;
    logic [1:0]         op_q;
    logic               hi_clear;
    state_t             state;
    state_t             state_nxt;

    // Any nonzero padding bit means the register was corrupted; treat that
    // as S_WAIT so the FSM recovers on the next edge.
    generate
        if (STATE_W > 3) begin : g_wide
            assign hi_clear = (state_q[STATE_W-1:3] == '0);
        end else begin : g_narrow
            assign hi_clear = 1'b1;
        end
    endgenerate

    assign state = hi_clear ? state_t'(state_q[2:0]) : S_WAIT;

    always_comb begin
        state_nxt = state;
        case (state)
            S_WAIT: begin
                if (s) state_nxt = S_DECODE;
            end
            S_DECODE: begin
                case ({opc_q, op_q})
                    {OPC_MOV, OP_MOVIMM}: state_nxt = S_WRITE_IMM;
                    {OPC_MOV, OP_MOVREG},
                    {OPC_ALU, OP_MVN}:    state_nxt = S_GET_B;
                    {OPC_ALU, OP_ADD},
                    {OPC_ALU, OP_CMP},
                    {OPC_ALU, OP_AND}:    state_nxt = S_GET_A;
`ifdef SR_ILLEGAL_TRAP_EN
                    default:              state_nxt = S_HALT;
`else
                    default:              state_nxt = S_WAIT;
`endif
                endcase
            end
            S_WRITE_IMM: state_nxt = S_WAIT;
            S_GET_A:     state_nxt = S_GET_B;
            S_GET_B:     state_nxt = S_ALU;
            S_ALU:       state_nxt = is_cmp(opc_q, op_q) ? S_WAIT : S_WRITE_REG;
            S_WRITE_REG: state_nxt = S_WAIT;
`ifdef SR_ILLEGAL_TRAP_EN
            S_HALT:      state_nxt = S_HALT;
`else
            S_HALT:      state_nxt = S_WAIT;
`endif
            default:     state_nxt = S_WAIT;
        endcase
    end

    // The instruction fields are captured once on start; everything after
    // S_WAIT decodes from this copy so decoder changes mid-instruction are ignored.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= STATE_W'(S_WAIT);
            opc_q   <= 3'b000;
            op_q    <= 2'b00;
        end else begin
            state_q <= STATE_W'(state_nxt);
            if (state == S_WAIT && s) begin
                opc_q <= opcode;
                op_q  <= op;
            end
        end
    end

    sr_ctrl_outdec u_outdec (
        .state   (state),
        .opcode  (opc_q),
        .op      (op_q),
        .w       (w),
        .nsel    (nsel),
        .vsel    (vsel),
        .loada   (loada),
        .loadb   (loadb),
        .loadc   (loadc),
        .loads   (loads),
        .asel    (asel),
        .bsel    (bsel),
        .write   (write),
        .illegal (illegal)
    );

endmodule

// File: tb/tb_sr_controller.sv
// tb/tb_sr_controller.sv - directed self-checking bench for sr_controller
module tb_sr_controller;

    logic       clk;
    logic       reset_n;
    logic       s;
    logic [2:0] opcode;
    logic [1:0] op;
    logic       w;
    logic [2:0] nsel;
    logic [1:0] vsel;
    logic       loada, loadb, loadc, loads, asel, bsel, write, illegal;

    int errors = 0;
    int checks = 0;

    // {w, nsel[2:0], vsel[1:0], loada, loadb, loadc, loads, asel, bsel, write, illegal}
    logic [13:0] outv;
    assign outv = {w, nsel, vsel, loada, loadb, loadc, loads, asel, bsel, write, illegal};

    localparam logic [13:0] O_WAIT    = 14'b1_000_00_0_0_0_0_0_0_0_0;
    localparam logic [13:0] O_DEC     = 14'b0_000_00_0_0_0_0_0_0_0_0;
    localparam logic [13:0] O_WIMM    = 14'b0_001_10_0_0_0_0_0_0_1_0;
    localparam logic [13:0] O_GETA    = 14'b0_001_00_1_0_0_0_0_0_0_0;
    localparam logic [13:0] O_GETB    = 14'b0_100_00_0_1_0_0_0_0_0_0;
    localparam logic [13:0] O_ALU_C   = 14'b0_000_00_0_0_1_0_0_0_0_0;
    localparam logic [13:0] O_ALU_CMP = 14'b0_000_00_0_0_0_1_0_0_0_0;
    localparam logic [13:0] O_ALU_MV  = 14'b0_000_00_0_0_1_0_1_0_0_0;
    localparam logic [13:0] O_WREG    = 14'b0_010_00_0_0_0_0_0_0_1_0;
    localparam logic [13:0] O_HALT    = 14'b0_000_00_0_0_0_0_0_0_0_1;

    sr_controller #(.STATE_W(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .s       (s),
        .opcode  (opcode),
        .op      (op),
        .w       (w),
        .nsel    (nsel),
        .vsel    (vsel),
        .loada   (loada),
        .loadb   (loadb),
        .loadc   (loadc),
        .loads   (loads),
        .asel    (asel),
        .bsel    (bsel),
        .write   (write),
        .illegal (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [13:0] got, input logic [13:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input string tag, input logic [13:0] exp);
        tick();
        check(tag, outv, exp);
    endtask

    // Present an instruction and pulse s for the sampling edge; leaves s low.
    task automatic start(input string tag, input logic [2:0] opc, input logic [1:0] o,
                         input logic [13:0] exp_edge1);
        opcode = opc;
        op     = o;
        s      = 1'b1;
        step(tag, exp_edge1);
        s      = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        check("reset_async", outv, O_WAIT);
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        s       = 1'b0;
        opcode  = 3'b000;
        op      = 2'b00;
        #2;
        check("reset_state", outv, O_WAIT);
        tick();
        tick();
        reset_n = 1'b1;
        step("idle_s0_a", O_WAIT);
        step("idle_s0_b", O_WAIT);

        // MOV imm: w back on edge 3
        start("movimm_e1", 3'b110, 2'b10, O_DEC);
        step("movimm_e2", O_WIMM);
        step("movimm_e3", O_WAIT);

        // ADD: w back on edge 6
        start("add_e1", 3'b101, 2'b00, O_DEC);
        step("add_e2", O_GETA);
        step("add_e3", O_GETB);
        step("add_e4", O_ALU_C);
        step("add_e5", O_WREG);
        step("add_e6", O_WAIT);

        // CMP: flags only, no write, w back on edge 5
        start("cmp_e1", 3'b101, 2'b01, O_DEC);
        step("cmp_e2", O_GETA);
        step("cmp_e3", O_GETB);
        step("cmp_e4", O_ALU_CMP);
        step("cmp_e5", O_WAIT);

        // AND follows the ADD path
        start("and_e1", 3'b101, 2'b10, O_DEC);
        step("and_e2", O_GETA);
        step("and_e3", O_GETB);
        step("and_e4", O_ALU_C);
        step("and_e5", O_WREG);
        step("and_e6", O_WAIT);

        // MOV reg: w back on edge 5
        start("movreg_e1", 3'b110, 2'b00, O_DEC);
        step("movreg_e2", O_GETB);
        step("movreg_e3", O_ALU_MV);
        step("movreg_e4", O_WREG);
        step("movreg_e5", O_WAIT);

        // MVN with opcode changed to MOV imm during S_GET_B and s held high:
        // the MVN path completes, w is up one cycle, then MOV imm runs.
        opcode = 3'b101;
        op     = 2'b11;
        s      = 1'b1;
        step("mvn_e1", O_DEC);
        step("mvn_e2", O_GETB);
        opcode = 3'b110;
        op     = 2'b10;
        step("mvn_e3", O_ALU_MV);
        step("mvn_e4", O_WREG);
        step("mvn_e5", O_WAIT);
        step("mvn_next_e1", O_DEC);
        s = 1'b0;
        step("mvn_next_e2", O_WIMM);
        step("mvn_next_e3", O_WAIT);

        // Async reset mid-S_ALU of an ADD
        start("rst_add_e1", 3'b101, 2'b00, O_DEC);
        step("rst_add_e2", O_GETA);
        step("rst_add_e3", O_GETB);
        step("rst_add_e4", O_ALU_C);
        do_reset();
        step("rst_after_a", O_WAIT);
        step("rst_after_b", O_WAIT);

        // Undefined instructions
`ifdef SR_ILLEGAL_TRAP_EN
        start("ill111_e1", 3'b111, 2'b00, O_DEC);
        step("ill111_e2", O_HALT);
        s = 1'b1;
        for (int i = 0; i < 5; i++) step("ill111_hold", O_HALT);
        s = 1'b0;
        do_reset();
        step("ill111_after", O_WAIT);
        start("ill110_e1", 3'b110, 2'b01, O_DEC);
        step("ill110_e2", O_HALT);
        step("ill110_e3", O_HALT);
        do_reset();
        step("ill110_after", O_WAIT);
`else
        start("ill111_e1", 3'b111, 2'b00, O_DEC);
        step("ill111_e2", O_WAIT);
        step("ill111_e3", O_WAIT);
        start("ill110_e1", 3'b110, 2'b01, O_DEC);
        step("ill110_e2", O_WAIT);
        start("ill110b_e1", 3'b110, 2'b11, O_DEC);
        step("ill110b_e2", O_WAIT);
`endif

        // Latched fields stay valid after an undefined op: a clean MOV imm still works
        start("post_movimm_e1", 3'b110, 2'b10, O_DEC);
        step("post_movimm_e2", O_WIMM);
        step("post_movimm_e3", O_WAIT);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
